// File: rtl/display_window_scheduler_if.sv
// Signal bundle between the multiplier datapath/buttons and the
// seven-segment window scheduler.
interface display_window_scheduler_if;
  logic [19:0] bcd;
  logic        sign;
  logic        BTNL;
  logic        BTNR;
  logic [3:0]  an;
  logic [3:0]  digit;
  logic        dash;
  logic        blank;
  logic [1:0]  win;
  logic        sa;
  logic        sb;
  logic        sc;

  modport master (
    output bcd, sign, BTNL, BTNR,
    input  an, digit, dash, blank, win, sa, sb, sc
  );

  modport slave (
    input  bcd, sign, BTNL, BTNR,
    output an, digit, dash, blank, win, sa, sb, sc
  );
endinterface

// File: rtl/display_window_scheduler.sv
// Debounces BTNL/BTNR into a saturating 3-digit window over a 5-digit BCD
// product and scans it onto a 4-digit seven-segment display with a sign slot.
module display_window_scheduler #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_CYCLES     = 100000
) (
  input logic                        clk,
  input logic                        rst,
  display_window_scheduler_if.slave  bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SC_W = $clog2(SCAN_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_CYCLES - 1);

  // Index 0 is the left button, index 1 the right button.
  logic [1:0] btn_raw;
  logic [1:0] press;
  assign btn_raw = {bus.BTNR, bus.BTNL};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            sync0_reg;
      logic            sync1_reg;
      logic            stable_reg;
      logic            stable_dly_reg;
      logic [DB_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync0_reg      <= 1'b0;
          sync1_reg      <= 1'b0;
          stable_reg     <= 1'b0;
          stable_dly_reg <= 1'b0;
          cnt_reg        <= '0;
        end else begin
          sync0_reg      <= btn_raw[gi];
          sync1_reg      <= sync0_reg;
          stable_dly_reg <= stable_reg;
          if (sync1_reg != stable_reg) begin
            if (cnt_reg == DB_LAST) begin
              stable_reg <= ~stable_reg;
              cnt_reg    <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign press[gi] = stable_reg & ~stable_dly_reg;
    end
  endgenerate

  // Nibbles 5..7 are never addressed but keep the index fully decoded.
  logic [3:0] nib [8];
  logic [7:0] upper_zero;

  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      if (gi < 5) begin : g_real
        assign nib[gi]        = bus.bcd[4*gi +: 4];
        assign upper_zero[gi] = (bus.bcd[19:4*gi] == '0);
      end else begin : g_pad
        assign nib[gi]        = 4'd0;
        assign upper_zero[gi] = 1'b1;
      end
    end
  endgenerate

  logic [1:0]      win_reg;
  logic [1:0]      slot_reg;
  logic [SC_W-1:0] refresh_reg;
  logic [3:0]      an_reg, an_next;
  logic [3:0]      digit_reg, digit_next;
  logic            dash_reg, dash_next;
  logic            blank_reg, blank_next;
  logic [2:0]      idx;

  assign idx = {1'b0, win_reg} + {1'b0, slot_reg};

  always_comb begin
    an_next    = 4'b1111;
    digit_next = 4'd0;
    dash_next  = 1'b0;
    blank_next = 1'b0;
    if (slot_reg == 2'd3) begin
      an_next    = 4'b0111;
      dash_next  = bus.sign;
      blank_next = ~bus.sign;
    end else begin
      an_next    = ~(4'b0001 << slot_reg);
      digit_next = nib[idx];
      // The rightmost digit always shows, even when it is a zero.
      blank_next = (slot_reg != 2'd0) && upper_zero[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_reg     <= 2'd0;
      slot_reg    <= 2'd0;
      refresh_reg <= '0;
      an_reg      <= 4'b1111;
      digit_reg   <= 4'd0;
      dash_reg    <= 1'b0;
      blank_reg   <= 1'b1;
    end else begin
      case ({press[1], press[0]})
        2'b01:   if (win_reg != 2'd2) win_reg <= win_reg + 2'd1;
        2'b10:   if (win_reg != 2'd0) win_reg <= win_reg - 2'd1;
        default: win_reg <= win_reg;
      endcase

      if (refresh_reg == SC_LAST) begin
        refresh_reg <= '0;
        slot_reg    <= slot_reg + 2'd1;
      end else begin
        refresh_reg <= refresh_reg + 1'b1;
      end

      an_reg    <= an_next;
      digit_reg <= digit_next;
      dash_reg  <= dash_next;
      blank_reg <= blank_next;
    end
  end

  assign bus.an    = an_reg;
  assign bus.digit = digit_reg;
  assign bus.dash  = dash_reg;
  assign bus.blank = blank_reg;
  assign bus.win   = win_reg;
  assign bus.sa    = (win_reg == 2'd0);
  assign bus.sb    = (win_reg == 2'd1);
  assign bus.sc    = (win_reg == 2'd2);

endmodule

// File: doc/display_window_scheduler.md
Name: display_window_scheduler

Overview:
- Sequences the 4-digit seven-segment display for the signed multiplier result.
- Takes the 5-digit BCD product and its sign, plus the raw BTNL/BTNR buttons.
- Synchronises and debounces both buttons and turns each press into a single-cycle pulse.
- Keeps a saturating 3-digit window position and time-multiplexes the anodes, driving one digit per scan slot, with leading-zero blanking and a sign slot.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed before a button level is accepted (5 ms at 100 MHz)
SCAN_CYCLES, 100000, clock cycles each anode stays active (1 ms at 100 MHz)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
bcd  input  20  five BCD digits; bcd[3:0] least significant, bcd[19:16] most significant
sign  input  1  1 = product negative
BTNL  input  1  raw left button (shift window toward higher digits)
BTNR  input  1  raw right button (shift window toward lower digits)
an  output  4  anode enables, active-low, one-hot-zero; an[0] is the rightmost digit
digit  output  4  BCD value for the active anode
dash  output  1  active slot shows a minus sign
blank  output  1  active slot shows nothing
win  output  2  window position 0..2
sa  output  1  win==0
sb  output  1  win==1
sc  output  1  win==2

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - win=0, sa=1, sb=0, sc=0
  - an=4'b1111, digit=0, dash=0, blank=1
  - scan slot=0, refresh counter=0
  - debounce counters=0, stable button levels=0
- Each button passes through a 2-flop synchroniser, then its own debounce counter.
  - Counter increments while the synchronised level differs from the stable level.
  - Counter clears on any cycle where they match.
  - When the count reaches DEBOUNCE_CYCLES-1, the stable level flips and the counter clears.
- Press pulse: one cycle, generated on the 0->1 transition of the stable level. A held button produces exactly one pulse.
- Window update, on the cycle after the pulse:
  - L pulse: win = min(win+1, 2).
  - R pulse: win = max(win-1, 0).
  - L and R pulses in the same cycle: win unchanged.
- sa/sb/sc are decoded combinationally from win and are always one-hot.
- Scan:
  - Refresh counter counts 0..SCAN_CYCLES-1 and wraps.
  - On wrap, slot advances 0->1->2->3->0.
  - The slot counter is never reset by a window change.
- Slot mapping (k = 0..2):
  - Slot k drives an[k] low with nibble index n = win+k.
  - Slot 3 is the sign position, driving an[3] low: dash=sign, blank=~sign, digit=0.
- Leading-zero blanking:
  - Slot 0 is never blanked.
  - Slot 1 or 2 has blank=1 when its nibble and every nibble above it in bcd are zero; otherwise blank=0.
  - dash=0 on slots 0-2.
- Output registration:
  - an, digit, dash and blank are registered from the current slot, win and bcd, so they lag slot/win changes by 1 cycle.
  - A window change mid-slot takes effect on the next registered update, without waiting for a slot change.
- Nibble values >9 are passed through to digit unmodified; no range checking.
- bcd and sign are sampled every cycle, so a changing product updates the display within 1 cycle.
- Reset asserted mid-operation returns every register to its reset value immediately. Scanning resumes at slot 0 with an=4'b1110 one cycle after reset release.

Test Plan:
- All tests run with DEBOUNCE_CYCLES=4 and SCAN_CYCLES=3.
- Reset: assert rst mid-scan -> an=4'b1111, blank=1, win=0, sa=1. Release -> an steps 1110, 1101, 1011, 0111 on successive 3-cycle slots.
- bcd=20'h12345, sign=1, win=0 -> slot0 digit=5, slot1 digit=4, slot2 digit=3; slot3 dash=1, blank=0.
- BTNL clean press held 20 cycles -> exactly one pulse and win 0->1. Slot0 digit=4, slot2 digit=2.
- Two more BTNL presses -> win=2, sc=1, slot2 digit=1.
- BTNR then BTNR then BTNR -> win 2->1->0->0, saturating.
- BTNL high for 2 cycles, low, high for 2 cycles (bounce shorter than the threshold) -> no pulse, win unchanged.
- BTNL and BTNR with identical timing -> win unchanged.
- bcd=20'h00007, sign=0 -> slot0 digit=7 blank=0; slot1 blank=1; slot2 blank=1; slot3 blank=1, dash=0.
- bcd=20'h00007 at win=2 -> slot0 digit=0 with blank=0, since slot 0 is never blanked.
